// File: rtl/wb_port_arb.sv
// wb_port_arb: shares the single register-file write port between the
// pipeline write-back and a FIFO of multi-cycle (mul/div) results.
// The pipeline has priority unless the FIFO head has been denied
// STARVE_MAX cycles, in which case write-back is stalled for one cycle.
`timescale 1ns/1ps
module wb_port_arb #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ws_reg_wen,
  input  logic [4:0]              ws_rd,
  input  logic [31:0]             ws_reg_wdata,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [4:0]              md_rd,
  input  logic [31:0]             md_wdata,
  output logic                    rf_wen,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    ws_stall,
  output logic [31:0]             md_pend_mask,
  output logic [$clog2(DEPTH):0]  md_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    starve_cnt;
  logic          rst_q;
  logic [CW-1:0] pend_cnt [32];

  logic        empty;
  logic        full;
  logic        pipe_req;
  logic        starve;
  logic        head_sel;
  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // Port arbitration and handshake; stall and ready use registered state only.
  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    head_rd   = rd_mem[rd_ptr];
    head_data = data_mem[rd_ptr];
    pipe_req  = ws_reg_wen && (ws_rd != 5'd0);
    starve    = !empty && (starve_cnt == STARVE_LIM);
    ws_stall  = starve;
    // rst_q keeps the FIFO closed while reset is being held.
    md_ready  = !full && !rst_q;
    head_sel  = starve || !pipe_req;
    push      = !rst && md_valid && md_ready && (md_rd != 5'd0);
    pop       = !rst && !empty && head_sel;
    rf_wen    = !rst && (pipe_req || !empty);
    if (head_sel) begin
      rf_waddr = head_rd;
      rf_wdata = head_data;
    end else begin
      rf_waddr = ws_rd;
      rf_wdata = ws_reg_wdata;
    end
    md_count  = count;
  end

  // FIFO pointers, occupancy and head starvation counter.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (empty || pop)                 starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // FIFO storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= md_rd;
      data_mem[wr_ptr] <= md_wdata;
    end
  end

  // Per-register count of buffered results; x0 is never enqueued.
  always_ff @(posedge clk) begin
    for (int unsigned r = 1; r < 32; r++) begin
      if (rst)
        pend_cnt[r] <= '0;
      else if (push && md_rd == 5'(r) && !(pop && head_rd == 5'(r)))
        pend_cnt[r] <= pend_cnt[r] + 1'b1;
      else if (pop && head_rd == 5'(r) && !(push && md_rd == 5'(r)))
        pend_cnt[r] <= pend_cnt[r] - 1'b1;
    end
    pend_cnt[0] <= '0;
  end

  // Pending mask for the hazard unit.
  always_comb begin
    md_pend_mask = '0;
    for (int unsigned r = 1; r < 32; r++)
      md_pend_mask[r] = (pend_cnt[r] != '0);
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed scenarios plus a random
// run compared against a queue-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_wb_port_arb;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ws_reg_wen;
  logic [4:0]  ws_rd;
  logic [31:0] ws_reg_wdata;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_stall;
  logic [31:0] md_pend_mask;
  logic [1:0]  md_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  wb_port_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ws_reg_wen(ws_reg_wen), .ws_rd(ws_rd), .ws_reg_wdata(ws_reg_wdata),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wdata(md_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_stall(ws_stall), .md_pend_mask(md_pend_mask), .md_count(md_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ws_reg_wen = 1'b0; ws_rd = '0; ws_reg_wdata = '0;
    md_valid = 1'b0; md_rd = '0; md_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; ws_reg_wen = 1'b1; ws_rd = 5'd7; md_valid = 1'b1; md_rd = 5'd5;
    tick(); #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", rf_wen); end
    checks++; if (ws_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", ws_stall); end
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", md_ready); end
    rst = 1'b0; idle_inputs();
    tick(); #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", md_ready); end
    checks++; if (md_count !== 2'd0) begin errors++; $display("FAIL post_rst_count: got %0d want 0", md_count); end
    checks++; if (md_pend_mask !== 32'h0) begin errors++; $display("FAIL post_rst_mask: got %h want 0", md_pend_mask); end
  endtask

  task automatic test_idle_port();
    do_reset();
    md_valid = 1'b1; md_rd = 5'd5; md_wdata = 32'hDEADBEEF; #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", md_ready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL idle_nobypass: got %b want 0", rf_wen); end
    tick(); idle_inputs(); #1;
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL idle_wen: got %b want 1", rf_wen); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL idle_addr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_data: got %h want deadbeef", rf_wdata); end
    checks++; if (md_pend_mask !== 32'h20) begin errors++; $display("FAIL idle_mask1: got %h want 20", md_pend_mask); end
    tick(); #1;
    checks++; if (md_pend_mask !== 32'h0) begin errors++; $display("FAIL idle_mask2: got %h want 0", md_pend_mask); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL idle_wen2: got %b want 0", rf_wen); end
  endtask

  task automatic test_starvation();
    do_reset();
    ws_reg_wen = 1'b1; ws_rd = 5'd7; ws_reg_wdata = 32'h77;
    md_valid = 1'b1; md_rd = 5'd3; md_wdata = 32'h33; #1;
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL starve_c0_addr: got %0d want 7", rf_waddr); end
    tick(); md_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || ws_stall !== 1'b0) begin
        errors++; $display("FAIL starve_pipe_c%0d: got wen=%b addr=%0d stall=%b want 1/7/0", c, rf_wen, rf_waddr, ws_stall);
      end
      tick();
    end
    #1;
    checks++; if (ws_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", ws_stall); end
    checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin errors++; $display("FAIL starve_head: got %0d/%h want 3/33", rf_waddr, rf_wdata); end
    tick(); #1;
    checks++; if (ws_stall !== 1'b0 || rf_waddr !== 5'd7) begin errors++; $display("FAIL starve_after: got stall=%b addr=%0d want 0/7", ws_stall, rf_waddr); end
    checks++; if (md_count !== 2'd0) begin errors++; $display("FAIL starve_count: got %0d want 0", md_count); end
  endtask

  task automatic test_full();
    do_reset();
    ws_reg_wen = 1'b1; ws_rd = 5'd7; ws_reg_wdata = 32'h77;
    md_valid = 1'b1; md_rd = 5'd10; md_wdata = 32'hA0;
    tick();
    md_rd = 5'd11; md_wdata = 32'hB0; #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b want 1", md_ready); end
    tick();
    md_rd = 5'd12; md_wdata = 32'hC0;
    for (int c = 2; c <= 5; c++) begin
      #1;
      checks++; if (md_ready !== 1'b0 || md_count !== 2'd2) begin
        errors++; $display("FAIL full_c%0d: got ready=%b count=%0d want 0/2", c, md_ready, md_count);
      end
      if (c == 5) begin
        checks++; if (ws_stall !== 1'b1 || rf_waddr !== 5'd10) begin
          errors++; $display("FAIL full_pop: got stall=%b addr=%0d want 1/10", ws_stall, rf_waddr);
        end
      end
      tick();
    end
    #1;
    checks++; if (md_ready !== 1'b1 || md_count !== 2'd1) begin errors++; $display("FAIL full_reopen: got ready=%b count=%0d want 1/1", md_ready, md_count); end
    tick(); idle_inputs(); #1;
    checks++; if (md_count !== 2'd2 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB0) begin
      errors++; $display("FAIL full_drain1: got count=%0d addr=%0d data=%h want 2/11/b0", md_count, rf_waddr, rf_wdata);
    end
    tick(); #1;
    checks++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'hC0) begin errors++; $display("FAIL full_drain2: got %0d/%h want 12/c0", rf_waddr, rf_wdata); end
    tick(); #1;
    checks++; if (md_count !== 2'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", md_count); end
  endtask

  task automatic test_x0();
    do_reset();
    md_valid = 1'b1; md_rd = 5'd0; md_wdata = 32'h1234; #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", md_ready); end
    tick(); idle_inputs(); #1;
    checks++; if (md_count !== 2'd0 || rf_wen !== 1'b0) begin errors++; $display("FAIL x0_drop: got count=%0d wen=%b want 0/0", md_count, rf_wen); end
    md_valid = 1'b1; md_rd = 5'd9; md_wdata = 32'h99;
    ws_reg_wen = 1'b1; ws_rd = 5'd0; ws_reg_wdata = 32'h55; #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_pipe: got %b want 0", rf_wen); end
    tick(); md_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || ws_stall !== 1'b0) begin
      errors++; $display("FAIL x0_head: got wen=%b addr=%0d data=%h stall=%b want 1/9/99/0", rf_wen, rf_waddr, rf_wdata, ws_stall);
    end
    tick(); idle_inputs(); #1;
    checks++; if (md_count !== 2'd0) begin errors++; $display("FAIL x0_count: got %0d want 0", md_count); end
  endtask

  task automatic test_duplicate();
    do_reset();
    ws_reg_wen = 1'b1; ws_rd = 5'd7; ws_reg_wdata = 32'h77;
    md_valid = 1'b1; md_rd = 5'd4; md_wdata = 32'h40;
    tick();
    md_wdata = 32'h41; #1;
    checks++; if (md_pend_mask !== 32'h10) begin errors++; $display("FAIL dup_mask0: got %h want 10", md_pend_mask); end
    tick(); idle_inputs(); #1;
    checks++; if (md_count !== 2'd2 || md_pend_mask !== 32'h10 || rf_waddr !== 5'd4 || rf_wdata !== 32'h40) begin
      errors++; $display("FAIL dup_first: got count=%0d mask=%h addr=%0d data=%h want 2/10/4/40", md_count, md_pend_mask, rf_waddr, rf_wdata);
    end
    tick(); #1;
    checks++; if (md_pend_mask !== 32'h10 || rf_wdata !== 32'h41) begin
      errors++; $display("FAIL dup_second: got mask=%h data=%h want 10/41", md_pend_mask, rf_wdata);
    end
    tick(); #1;
    checks++; if (md_pend_mask !== 32'h0) begin errors++; $display("FAIL dup_clear: got %h want 0", md_pend_mask); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ws_reg_wen = 1'b1; ws_rd = 5'd7; ws_reg_wdata = 32'h77;
    md_valid = 1'b1; md_rd = 5'd12; md_wdata = 32'hC0;
    tick();
    md_rd = 5'd13; md_wdata = 32'hD0;
    tick();
    md_valid = 1'b0; rst = 1'b1; #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rmid_wen: got %b want 0", rf_wen); end
    tick(); rst = 1'b0; idle_inputs(); #1;
    checks++; if (md_count !== 2'd0 || md_pend_mask !== 32'h0 || rf_wen !== 1'b0) begin
      errors++; $display("FAIL rmid_clear: got count=%0d mask=%h wen=%b want 0/0/0", md_count, md_pend_mask, rf_wen);
    end
    tick(); #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", md_ready); end
  endtask

  task automatic test_random(int unsigned n);
    ent_t q[$];
    int scnt;
    scnt = 0;
    do_reset();
    for (int unsigned k = 0; k < n; k++) begin
      bit          starve, preq, take_head, e_wen, accepted;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_mask;
      ws_reg_wen   = ($urandom_range(0, 3) != 0);
      ws_rd        = 5'($urandom_range(0, 7));
      ws_reg_wdata = $urandom;
      md_valid     = ($urandom_range(0, 1) == 1);
      md_rd        = 5'($urandom_range(0, 6));
      md_wdata     = $urandom;
      #1;
      starve    = (q.size() != 0) && (scnt == STARVE_MAX);
      preq      = ws_reg_wen && (ws_rd != 5'd0);
      take_head = (q.size() != 0) && (starve || !preq);
      e_wen     = take_head || preq;
      e_addr    = take_head ? q[0].rd : ws_rd;
      e_data    = take_head ? q[0].d  : ws_reg_wdata;
      e_mask    = '0;
      foreach (q[i]) e_mask[q[i].rd] = 1'b1;
      accepted  = md_valid && (q.size() < DEPTH);
      checks++; if (rf_wen !== e_wen) begin errors++; $display("FAIL rnd_wen@%0d: got %b want %b", k, rf_wen, e_wen); end
      if (e_wen) begin
        checks++; if (rf_waddr !== e_addr || rf_wdata !== e_data) begin
          errors++; $display("FAIL rnd_port@%0d: got %0d/%h want %0d/%h", k, rf_waddr, rf_wdata, e_addr, e_data);
        end
      end
      checks++; if (ws_stall !== starve) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", k, ws_stall, starve); end
      checks++; if (md_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", k, md_ready, q.size() < DEPTH); end
      checks++; if (md_count !== 2'(q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", k, md_count, q.size()); end
      checks++; if (md_pend_mask !== e_mask) begin errors++; $display("FAIL rnd_mask@%0d: got %h want %h", k, md_pend_mask, e_mask); end
      @(posedge clk);
      if (take_head) begin
        void'(q.pop_front());
        scnt = 0;
      end else if (q.size() == 0) begin
        scnt = 0;
      end else if (scnt < STARVE_MAX) begin
        scnt++;
      end
      if (accepted && md_rd != 5'd0) q.push_back('{rd: md_rd, d: md_wdata});
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_idle_port();
    test_starvation();
    test_full();
    test_x0();
    test_duplicate();
    test_reset_mid();
    test_random(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
